fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences instruction fetch for the pipelined core.
- Owns the PC register and drives a variable-latency instruction memory through a req/ack handshake.
- Presents one fetched instruction at a time to decode, and applies redirects (taken branch, jump, register jump) and decode stalls from later stages.
- Replaces the free-running PC update of the single-cycle datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded by reset and first address fetched.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
redirect  in  1  taken branch/jump from execute; one-cycle pulse.
redirect_pc  in  32  target address, valid when redirect=1.
stall  in  1  decode cannot accept; holds the if_* outputs.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address; stable while imem_req=1 and no ack.
imem_ack  in  1  memory returns data this cycle; may coincide with the first req cycle.
imem_rdata  in  32  instruction word, valid when imem_ack=1.
if_valid  out  1  if_instr/if_pc hold a live instruction.
if_instr  out  32  fetched instruction.
if_pc  out  32  address of if_instr.
if_pc_plus4  out  32  if_pc+4, for link and branch-offset use.

Behaviour:
- Reset (reset=0 at posedge):
  - pc<=RESET_PC; state<=IDLE.
  - if_valid=0; if_instr=0; if_pc=0; if_pc_plus4=0; imem_req=0.
  - imem_addr=pc=RESET_PC.
- Reset asserted mid-request: the outstanding request is abandoned; the memory side must tolerate the dropped req.
- Consume: an instruction is consumed in any cycle with if_valid=1 and stall=0. The output slot is "free" if if_valid=0 or it is being consumed this cycle.
- States: IDLE, REQ, HOLD, DRAIN. imem_req=1 in REQ and DRAIN only.
- IDLE: go to REQ next cycle. Entered only from reset.
- REQ: imem_addr=pc.
  - ack and no redirect, slot free: load if_instr<=imem_rdata, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1; pc<=pc+4; stay REQ.
  - ack and no redirect, slot not free: impossible, because REQ is entered only with a free slot. Assertion required.
  - no ack, no redirect: hold pc and imem_addr; stay REQ.
- Throughput and latency:
  - Zero-wait memory (ack in the same cycle as req) with stall=0 gives one instruction per cycle.
  - Latency from req to if_valid is 1 cycle after ack.
- Going to HOLD: when the next cycle's slot is not free (a just-loaded instruction with stall=1, or an already-stalled instruction), go to HOLD and do not issue a new request.
- HOLD: imem_req=0. When stall=0 the slot is consumed; if_valid<=0 unless a new fetch lands; return to REQ.
- Redirect has the highest priority in every state, including over stall:
  - if_valid<=0 (flush) and pc<=redirect_pc.
  - REQ with ack in the same cycle: discard imem_rdata; stay REQ at the new pc.
  - REQ without ack: go to DRAIN. Keep imem_req=1 and imem_addr at the old address until ack, discard that data, then REQ at redirect_pc.
  - DRAIN: a further redirect overwrites pc only; the last redirect wins.
  - HOLD: go to REQ at redirect_pc.
- PC arithmetic: pc+4 is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 with no flag.
- Misaligned redirect_pc handling is defined under Optional Feature.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault sticky, flushes if_valid, and enters state FAULT. FAULT is terminal: imem_req=0 until reset. The state is drained first if a request is outstanding.
- Undefined: redirect_pc low two bits are forced to 0; there is no fault port and no FAULT state.

Decomposition:
- Shared package fetch_pkg:
  - state encoding (IDLE, REQ, HOLD, DRAIN, FAULT);
  - PC_INCR=4;
  - default RESET_PC constant.
- One sub-module fetch_out_buf: the if_* holding register with load, flush and stall-hold, whose free signal feeds the FSM.

Test Plan:
1. Reset, zero-wait memory (ack=req), stall=0 -> imem_addr 0x0,0x4,0x8,0xC on consecutive cycles; if_pc trails by 1 cycle; if_valid=1 from cycle 2.
2. Ack delayed 3 cycles at pc=0x10 -> imem_addr held at 0x10 for 3 cycles; if_valid=0 until the cycle after ack; if_instr=rdata.
3. Stall=1 for 4 cycles while if_pc=0x20 -> imem_req=0 during stall; if_pc/if_instr held; on release next fetch at 0x24.
4. Redirect to 0x100 while a request to 0x40 is pending without ack -> DRAIN keeps addr 0x40 until ack, data discarded, next imem_addr=0x100; no if_valid for 0x40.
5. Redirect and stall in the same cycle with if_valid=1 -> if_valid=0 next cycle; fetch resumes at redirect_pc.
6. With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> fetch_fault=1, imem_req=0 permanently; reset=0 clears fault and restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// FETCH_ALIGN_CHECK_EN adds the terminal FAULT state to the encoding.
package fetch_pkg;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN,
        FAULT
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN
    } fetch_state_e;
`endif

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// Holding register for the instruction presented to decode.
// Supports load, flush and stall-hold; free tells the sequencer a new word can land.
module fetch_out_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic        stall,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        free
);

    assign free = !if_valid || !stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            if_valid    <= 1'b0;
            if_instr    <= 32'h0000_0000;
            if_pc       <= 32'h0000_0000;
            if_pc_plus4 <= 32'h0000_0000;
        end else if (flush) begin
            if_valid <= 1'b0;
        end else if (load) begin
            if_valid    <= 1'b1;
            if_instr    <= load_instr;
            if_pc       <= load_pc;
            if_pc_plus4 <= load_pc + PC_INCR;
        end else if (if_valid && !stall) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the req/ack memory port, applies redirects.
// FETCH_ALIGN_CHECK_EN adds fetch_fault and a terminal FAULT state for misaligned redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    // state | meaning
    // IDLE  | first cycle out of reset, no request
    // REQ   | request at pc while the output slot is free
    // HOLD  | decode stalled on a live instruction, no request
    // DRAIN | wait out the ack of a request abandoned by a redirect
    // FAULT | misaligned redirect seen, fetch halted until reset

    fetch_state_e state;
    fetch_state_e state_nxt;
    logic [31:0]  pc;
    logic [31:0]  pc_nxt;
    logic [31:0]  drain_addr;
    logic [31:0]  redirect_tgt;
    logic         slot_free;
    logic         buf_load;
    logic         buf_flush;
    logic         halted;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_nxt;
    assign redirect_tgt = redirect_pc;
    assign halted       = (state == FAULT);
`else
    assign redirect_tgt = align_pc(redirect_pc);
    assign halted       = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        imem_req  = 1'b0;
        imem_addr = pc;
        buf_load  = 1'b0;
        buf_flush = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_nxt = fetch_fault;
`endif

        // A request goes out only when its data could land, so an ack never meets a full slot.
        case (state)
            REQ:     imem_req = slot_free;
            DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_addr;
            end
            default: imem_req = 1'b0;
        endcase

        if (redirect && !halted) begin
            buf_flush = 1'b1;
            pc_nxt    = redirect_tgt;
            state_nxt = (imem_req && !imem_ack) ? DRAIN : REQ;
        end else begin
            case (state)
                IDLE: state_nxt = REQ;
                REQ: begin
                    if (imem_req && imem_ack) begin
                        buf_load = 1'b1;
                        pc_nxt   = pc + PC_INCR;
                        if (stall) begin
                            state_nxt = HOLD;
                        end
                    end else if (!slot_free) begin
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (slot_free) begin
                        state_nxt = REQ;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state_nxt = REQ;
                    end
                end
                default: state_nxt = state;
            endcase
        end

`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect && !halted && (redirect_pc[1:0] != 2'b00)) begin
            fault_nxt = 1'b1;
        end
        // A pending fault parks in FAULT once no request is left outstanding.
        if (fault_nxt && (state_nxt == REQ)) begin
            state_nxt = FAULT;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_fault <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= imem_addr;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_fault <= fault_nxt;
`endif
        end
    end

    fetch_out_buf u_out_buf (
        .clk         (clk),
        .reset       (reset),
        .load        (buf_load),
        .flush       (buf_flush),
        .stall       (stall),
        .load_instr  (imem_rdata),
        .load_pc     (pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .free        (slot_free)
    );

    ack_into_free_slot : assert property (
        @(posedge clk) disable iff (!reset)
        (state == REQ && imem_ack && !redirect) |-> slot_free
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl against a variable-latency memory model.
// Memory returns addr ^ 32'hC0DE_0000; mem_lat sets the number of wait cycles.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    int unsigned mem_lat = 0;
    int unsigned waited  = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) begin
        if (!imem_req || imem_ack) waited <= 0;
        else                       waited <= waited + 1;
    end
    assign imem_ack   = imem_req && (waited >= mem_lat);
    assign imem_rdata = word_at(imem_addr);

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault (fetch_fault)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to_addr(input logic [31:0] target);
        int n = 0;
        #1;
        while (!(imem_req && imem_addr == target) && n < 32) begin
            cyc();
            #1;
            n++;
        end
        check_eq("reach_addr", imem_addr, target);
    endtask

    initial begin
        logic [31:0] mis_off;
`ifdef FETCH_ALIGN_CHECK_EN
        mis_off = 32'd0;
`else
        mis_off = 32'd2;
`endif
        reset = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0; mem_lat = 0;
        cyc(); cyc(); #1;
        check_eq("rst_valid", if_valid, 0);
        check_eq("rst_instr", if_instr, 0);
        check_eq("rst_pc", if_pc, 0);
        check_eq("rst_pc4", if_pc_plus4, 0);
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_addr", imem_addr, 32'h0);

        // zero-wait streaming
        reset = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("t1_addr", imem_addr, 32'(4 * i));
            check_eq("t1_req", imem_req, 1);
            check_eq("t1_valid", if_valid, (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) begin
                check_eq("t1_pc", if_pc, 32'(4 * (i - 1)));
                check_eq("t1_instr", if_instr, word_at(32'(4 * (i - 1))));
            end
            cyc();
        end

        // three wait states at 0x10
        mem_lat = 3;
        for (int j = 0; j < 4; j++) begin
            #1;
            check_eq("t2_addr", imem_addr, 32'h10);
            check_eq("t2_valid", if_valid, (j == 0) ? 32'd1 : 32'd0);
            cyc();
        end
        mem_lat = 0; #1;
        check_eq("t2_valid_after", if_valid, 1);
        check_eq("t2_pc", if_pc, 32'h10);
        check_eq("t2_instr", if_instr, word_at(32'h10));
        check_eq("t2_next_addr", imem_addr, 32'h14);

        // decode stall on 0x20
        cyc(); cyc(); cyc(); cyc();
        stall = 1'b1; #1;
        check_eq("t3_pc_at_stall", if_pc, 32'h20);
        for (int s = 0; s < 4; s++) begin
            #1;
            check_eq("t3_req", imem_req, 0);
            check_eq("t3_valid", if_valid, 1);
            check_eq("t3_pc", if_pc, 32'h20);
            check_eq("t3_instr", if_instr, word_at(32'h20));
            cyc();
        end
        stall = 1'b0; #1;
        check_eq("t3_release_req", imem_req, 0);
        cyc(); #1;
        check_eq("t3_resume_addr", imem_addr, 32'h24);
        check_eq("t3_resume_req", imem_req, 1);
        check_eq("t3_bubble", if_valid, 0);
        cyc(); #1;
        check_eq("t3_next_pc", if_pc, 32'h24);

        // redirect during a pending request -> drain
        advance_to_addr(32'h40);
        mem_lat = 5; #1;
        check_eq("t4_req", imem_req, 1);
        cyc();
        redirect = 1'b1; redirect_pc = 32'h100; #1;
        check_eq("t4_addr_pending", imem_addr, 32'h40);
        cyc();
        redirect = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("t4_drain_addr", imem_addr, 32'h40);
            check_eq("t4_drain_req", imem_req, 1);
            check_eq("t4_drain_valid", if_valid, 0);
            cyc();
        end
        mem_lat = 0; #1;
        check_eq("t4_new_addr", imem_addr, 32'h100);
        check_eq("t4_no_valid", if_valid, 0);
        cyc(); #1;
        check_eq("t4_pc", if_pc, 32'h100);
        check_eq("t4_valid", if_valid, 1);

        // redirect and stall together
        redirect = 1'b1; redirect_pc = 32'h200; stall = 1'b1; #1;
        check_eq("t5_req", imem_req, 0);
        cyc();
        redirect = 1'b0; stall = 1'b0; #1;
        check_eq("t5_flushed", if_valid, 0);
        check_eq("t5_addr", imem_addr, 32'h200);
        cyc(); #1;
        check_eq("t5_pc", if_pc, 32'h200);
        check_eq("t5_pc4", if_pc_plus4, 32'h204);

        // redirect with same-cycle ack discards data; low bits masked in default build
        redirect = 1'b1; redirect_pc = 32'h300 | mis_off; #1;
        check_eq("t7_req", imem_req, 1);
        check_eq("t7_old_addr", imem_addr, 32'h204);
        cyc();
        redirect = 1'b0; #1;
        check_eq("t7_discard", if_valid, 0);
        check_eq("t7_addr", imem_addr, 32'h300);
        cyc(); #1;
        check_eq("t7_pc", if_pc, 32'h300);

        // wrap at top of address space, loaded with stall=1 -> HOLD
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0; stall = 1'b1; #1;
        check_eq("t8_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(); #1;
        check_eq("t8_hold_req", imem_req, 0);
        check_eq("t8_pc", if_pc, 32'hFFFF_FFFC);
        check_eq("t8_pc4_wrap", if_pc_plus4, 32'h0);
        stall = 1'b0;
        cyc(); #1;
        check_eq("t8_wrap_addr", imem_addr, 32'h0);
        cyc(); #1;
        check_eq("t8_pc_zero", if_pc, 32'h0);
        check_eq("t8_pc4", if_pc_plus4, 32'h4);

        // reset while a request is pending
        mem_lat = 3;
        cyc();
        reset = 1'b0;
        cyc(); #1;
        check_eq("t9_req", imem_req, 0);
        check_eq("t9_addr", imem_addr, 32'h0);
        check_eq("t9_valid", if_valid, 0);
        reset = 1'b1; mem_lat = 0;
        cyc(); #1;
        check_eq("t9_restart_addr", imem_addr, 32'h0);
        check_eq("t9_restart_req", imem_req, 1);
        cyc(); #1;
        check_eq("t9_valid_back", if_valid, 1);

`ifdef FETCH_ALIGN_CHECK_EN
        redirect = 1'b1; redirect_pc = 32'h102;
        cyc();
        redirect = 1'b0; #1;
        check_eq("t6_fault", fetch_fault, 1);
        check_eq("t6_valid", if_valid, 0);
        for (int f = 0; f < 3; f++) begin
            #1;
            check_eq("t6_req", imem_req, 0);
            cyc();
        end
        reset = 1'b0;
        cyc(); #1;
        check_eq("t6_fault_clr", fetch_fault, 0);
        reset = 1'b1;
        cyc(); #1;
        check_eq("t6_restart", imem_addr, 32'h0);
        check_eq("t6_restart_req", imem_req, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
